// File: rtl/car_types_pkg.sv
// car_types_pkg: shared lane types and intersection controller states
package car_types_pkg;
  typedef logic [7:0] car_counter_t;
  typedef enum logic [1:0] {RED, YELLOW, GREEN} strafic_light_t;
  typedef enum logic [1:0] {IDLE, GREEN_PH, YELLOW_PH, ALLRED_PH} ctrl_state_t;
endpackage

// File: rtl/intersection_ctrl_if.sv
// intersection_ctrl_if: lane counts in, lights/observation out; INTERSECTION_PREEMPT_EN adds preemption inputs
interface intersection_ctrl_if #(parameter int NUM_LANES = 4);
  import car_types_pkg::*;
  car_counter_t car_counter [NUM_LANES];
  strafic_light_t strafic_light [NUM_LANES];
  logic [$clog2(NUM_LANES)-1:0] active_lane;
  ctrl_state_t phase_state;
`ifdef INTERSECTION_PREEMPT_EN
  logic preempt_req;
  logic [$clog2(NUM_LANES)-1:0] preempt_lane;
  modport master (input car_counter, preempt_req, preempt_lane, output strafic_light, active_lane, phase_state);
  modport slave (output car_counter, preempt_req, preempt_lane, input strafic_light, active_lane, phase_state);
`else
  modport master (input car_counter, output strafic_light, active_lane, phase_state);
  modport slave (output car_counter, input strafic_light, active_lane, phase_state);
`endif
endinterface

// File: rtl/intersection_ctrl_rr_arbiter.sv
// rr_arbiter: first requesting lane at or after ptr, scanning upward with wrap
module rr_arbiter #(parameter int NUM_LANES = 4) (
  input  logic [NUM_LANES-1:0]         req,
  input  logic [$clog2(NUM_LANES)-1:0] ptr,
  output logic [$clog2(NUM_LANES)-1:0] grant,
  output logic                         valid
);
  localparam int LW = $clog2(NUM_LANES);
  // scan from the far end so the lane closest to ptr is written last and wins
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_LANES]) begin
        grant = LW'((int'(ptr) + i) % NUM_LANES);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: round-robin GREEN/YELLOW/ALL_RED sequencing of lane lights; INTERSECTION_PREEMPT_EN enables emergency preemption
module intersection_ctrl
  import car_types_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int MIN_GREEN     = 8,
  parameter int MAX_GREEN     = 32,
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  intersection_ctrl_if.master bus
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int TW = $clog2(MAX_GREEN + 1);
  localparam logic [LW-1:0] LAST = LW'(NUM_LANES - 1);
  ctrl_state_t state;
  strafic_light_t light [NUM_LANES];
  logic [TW-1:0] timer;
  logic [LW-1:0] active, ptr, nxt_ptr, arb_ptr, arb_lane, grant_lane, pre_lane;
  logic [NUM_LANES-1:0] req, act_mask;
  logic arb_valid, grant_valid, others, pre, go_yellow;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign req[i] = bus.car_counter[i] != '0;
    assign bus.strafic_light[i] = light[i];
  end
`ifdef INTERSECTION_PREEMPT_EN
  assign pre = bus.preempt_req;
  assign pre_lane = bus.preempt_lane;
`else
  assign pre = 1'b0;
  assign pre_lane = '0;
`endif
  assign bus.active_lane = active;
  assign bus.phase_state = state;
  assign act_mask = NUM_LANES'(1) << active;
  assign others = |(req & ~act_mask);
  assign nxt_ptr = active == LAST ? '0 : active + 1'b1;
  // on ALL_RED exit the scan must already start after the lane just served
  assign arb_ptr = state == IDLE ? ptr : nxt_ptr;
  assign grant_valid = pre | arb_valid;
  assign grant_lane = pre ? pre_lane : arb_lane;
  assign go_yellow = pre ? active != pre_lane
                         : others && (timer >= TW'(MAX_GREEN - 1) ||
                                      (timer >= TW'(MIN_GREEN - 1) && !req[active]));
  rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
    .req   (req),
    .ptr   (arb_ptr),
    .grant (arb_lane),
    .valid (arb_valid)
  );
  // phase FSM with timer and registered light decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      timer  <= '0;
      ptr    <= '0;
      active <= '0;
      for (int i = 0; i < NUM_LANES; i++) light[i] <= RED;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          state  <= GREEN_PH;
          active <= grant_lane;
          timer  <= '0;
          for (int i = 0; i < NUM_LANES; i++) light[i] <= i == int'(grant_lane) ? GREEN : RED;
        end
        GREEN_PH: if (go_yellow) begin
          state         <= YELLOW_PH;
          timer         <= '0;
          light[active] <= YELLOW;
        end else begin
          timer <= pre ? '0 : (timer == TW'(MAX_GREEN) ? timer : timer + 1'b1);
        end
        YELLOW_PH: if (timer == TW'(YELLOW_CYCLES - 1)) begin
          state         <= ALLRED_PH;
          timer         <= '0;
          light[active] <= RED;
        end else begin
          timer <= timer + 1'b1;
        end
        default: if (timer == TW'(ALLRED_CYCLES - 1)) begin
          ptr   <= nxt_ptr;
          timer <= '0;
          state <= grant_valid ? GREEN_PH : IDLE;
          if (grant_valid) begin
            active <= grant_lane;
            for (int i = 0; i < NUM_LANES; i++) light[i] <= i == int'(grant_lane) ? GREEN : RED;
          end
        end else begin
          timer <= timer + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed scoreboard bench for intersection_ctrl (INTERSECTION_PREEMPT_EN adds a preemption scenario)
module tb_intersection_ctrl;
  import car_types_pkg::*;
  localparam int N = 4, MIN_G = 8, MAX_G = 32, YEL = 4, ALLR = 2;
  typedef struct {string tag; int lane; int light; int st;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0, failures = 0, viol = 0, idle_bad, g, y, a, w;
  exp_t sb [$];
  strafic_light_t prev [N];
  intersection_ctrl_if #(.NUM_LANES(N)) bus ();
  intersection_ctrl #(.NUM_LANES(N), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
                      .YELLOW_CYCLES(YEL), .ALLRED_CYCLES(ALLR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  // safety monitor: one non-RED lane at most, GREEN never drops straight to RED
  always @(negedge clk) begin
    int nr;
    nr = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.strafic_light[i] != RED) nr++;
      if (rst_n && prev[i] == GREEN && bus.strafic_light[i] == RED) viol++;
      prev[i] = bus.strafic_light[i];
    end
    if (rst_n && nr > 1) viol++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input int lane, input strafic_light_t l, input ctrl_state_t s);
    sb.push_back('{tag, lane, int'(l), int'(s)});
  endtask
  task automatic sb_check();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, "_lane"}, int'(bus.active_lane), e.lane);
    chk({e.tag, "_light"}, int'(bus.strafic_light[e.lane]), e.light);
    chk({e.tag, "_state"}, int'(bus.phase_state), e.st);
  endtask
  task automatic measure(input int lane, output int gc, output int yc, output int ac);
    gc = 0; yc = 0; ac = 0;
    while (bus.strafic_light[lane] == GREEN && gc < 200) begin gc++; tick(1); end
    while (bus.strafic_light[lane] == YELLOW && yc < 200) begin yc++; tick(1); end
    while (bus.phase_state == ALLRED_PH && ac < 200) begin ac++; tick(1); end
  endtask
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) bus.car_counter[i] = '0;
`ifdef INTERSECTION_PREEMPT_EN
    bus.preempt_req = 1'b0;
    bus.preempt_lane = '0;
`endif
    tick(3);
    for (int i = 0; i < N; i++) chk($sformatf("reset_light%0d", i), int'(bus.strafic_light[i]), int'(RED));
    chk("reset_active", int'(bus.active_lane), 0);
    chk("reset_state", int'(bus.phase_state), int'(IDLE));
    rst_n = 1'b1;
    idle_bad = 0;
    repeat (50) begin
      tick(1);
      if (bus.phase_state != IDLE) idle_bad++;
      for (int i = 0; i < N; i++) if (bus.strafic_light[i] != RED) idle_bad++;
    end
    chk("idle_hold", idle_bad, 0);
    bus.car_counter[2] = 8'd3;
    push("t2_grant", 2, GREEN, GREEN_PH);
    tick(1);
    sb_check();
    tick(40);
    push("t2_rest", 2, GREEN, GREEN_PH);
    sb_check();
    bus.car_counter[2] = '0;
    bus.car_counter[0] = 8'd5;
    push("t3_lane0", 0, GREEN, GREEN_PH);
    measure(2, g, y, a);
    chk("t3a_green_tail", g, 1);
    chk("t3a_yellow", y, YEL);
    chk("t3a_allred", a, ALLR);
    sb_check();
    bus.car_counter[0] = '0;
    tick(2);
    bus.car_counter[1] = 8'd5;
    push("t3_lane1", 1, GREEN, GREEN_PH);
    measure(0, g, y, a);
    chk("t3_green_after_t2", g, MIN_G - 2);
    chk("t3_yellow", y, YEL);
    chk("t3_allred", a, ALLR);
    sb_check();
    bus.car_counter[0] = 8'd9;
    bus.car_counter[1] = 8'd9;
    push("t4_lane0", 0, GREEN, GREEN_PH);
    push("t4_lane1", 1, GREEN, GREEN_PH);
    measure(1, g, y, a);
    chk("t4_max_green_l1", g, MAX_G);
    sb_check();
    measure(0, g, y, a);
    chk("t4_max_green_l0", g, MAX_G);
    chk("t4_yellow", y, YEL);
    sb_check();
    bus.car_counter[0] = '0;
    bus.car_counter[3] = 8'd4;
    push("t5_lane3", 3, GREEN, GREEN_PH);
    measure(1, g, y, a);
    chk("t5_max_green", g, MAX_G);
    sb_check();
    w = 0;
    while (bus.strafic_light[3] != YELLOW && w < 100) begin w++; tick(1); end
    chk("t6_reach_yellow", int'(bus.strafic_light[3]), int'(YELLOW));
    tick(1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("t6_async_light%0d", i), int'(bus.strafic_light[i]), int'(RED));
    chk("t6_async_state", int'(bus.phase_state), int'(IDLE));
    chk("t6_async_active", int'(bus.active_lane), 0);
    tick(1);
    rst_n = 1'b1;
    push("t6_ptr0_grant", 1, GREEN, GREEN_PH);
    tick(1);
    sb_check();
`ifdef INTERSECTION_PREEMPT_EN
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) bus.car_counter[i] = '0;
    bus.car_counter[0] = 8'd2;
    tick(1);
    rst_n = 1'b1;
    push("p_lane0", 0, GREEN, GREEN_PH);
    tick(1);
    sb_check();
    tick(1);
    bus.preempt_req = 1'b1;
    bus.preempt_lane = 2'd3;
    push("p_yellow", 0, YELLOW, YELLOW_PH);
    tick(1);
    sb_check();
    push("p_lane3", 3, GREEN, GREEN_PH);
    measure(0, g, y, a);
    chk("p_yellow_len", y, YEL);
    sb_check();
    tick(MAX_G + 8);
    push("p_hold", 3, GREEN, GREEN_PH);
    sb_check();
    bus.preempt_req = 1'b0;
    push("p_resume_lane0", 0, GREEN, GREEN_PH);
    measure(3, g, y, a);
    chk("p_min_green_after", g, MIN_G);
    sb_check();
`endif
    chk("safety_monitor", viol, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
